// File: rtl/fetch_queue.sv
// Instruction fetch queue: 1-cycle-latency imem requests, DEPTH-entry FIFO of {pc, instr}, valid/ready to decode.
// Latency req->IFvalid is 2 cycles (1 with FETCH_QUEUE_BYPASS_EN); issue throttled by count+pending credits, so IFready low never overflows.
module fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4,
  parameter int          CW       = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  output logic          IFreq,
  output logic [31:0]   IFaddr,
  input  logic [31:0]   IFrdata,
  input  logic          IFredirect,
  input  logic [31:0]   IFtarget,
  output logic          IFvalid,
  input  logic          IFready,
  output logic [31:0]   IFinstr,
  output logic [31:0]   IFpc,
  output logic [CW-1:0] IFcount
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  logic [31:0]   fetch_pc;
  logic [31:0]   pend_pc;
  logic          pending;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [63:0]   mem [DEPTH];

  logic [63:0]   head;
  logic [CW:0]   credit_used;
  logic          q_vld;
  logic          push;
  logic          pop;

  assign head        = mem[rd_ptr];
  assign credit_used = {1'b0, count} + {{CW{1'b0}}, pending};
  assign q_vld       = (count != '0);
  assign IFaddr      = fetch_pc;
  assign IFcount     = count;
  assign IFreq       = !reset && !IFredirect && (credit_used < DEPTH_W);
  assign pop         = q_vld && IFready && !IFredirect;

`ifdef FETCH_QUEUE_BYPASS_EN
  logic byp_vld;
  assign byp_vld = !q_vld && pending && !IFredirect;

  always_comb begin
    IFvalid = q_vld || byp_vld;
    IFinstr = 32'h0;
    IFpc    = 32'h0;
    push    = pending && !IFredirect && !(byp_vld && IFready);
    if (q_vld) begin
      IFinstr = head[31:0];
      IFpc    = head[63:32];
    end else if (byp_vld) begin
      IFinstr = IFrdata;
      IFpc    = pend_pc;
    end
  end
`else
  always_comb begin
    IFvalid = q_vld;
    IFinstr = 32'h0;
    IFpc    = 32'h0;
    push    = pending && !IFredirect;
    if (q_vld) begin
      IFinstr = head[31:0];
      IFpc    = head[63:32];
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      pend_pc  <= 32'h0;
      pending  <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else if (IFredirect) begin
      // Drop queue contents and the in-flight response; restart at the word-aligned target.
      fetch_pc <= {IFtarget[31:2], 2'b00};
      pending  <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      pending <= IFreq;
      if (IFreq) begin
        fetch_pc <= fetch_pc + 32'd4;
        pend_pc  <= fetch_pc;
      end
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {pend_pc, IFrdata};
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue; the memory model answers each request with addr+0x100 one cycle later.
module tb_fetch_queue;

`ifdef FETCH_QUEUE_BYPASS_EN
  localparam int LAT = 1;
  localparam bit BYP = 1'b1;
`else
  localparam int LAT = 2;
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        IFreq;
  logic [31:0] IFaddr;
  logic [31:0] IFrdata = 32'hDEAD_BEEF;
  logic        IFredirect = 1'b0;
  logic [31:0] IFtarget = 32'h0;
  logic        IFvalid;
  logic        IFready = 1'b1;
  logic [31:0] IFinstr;
  logic [31:0] IFpc;
  logic [2:0]  IFcount;

  int n_cmp = 0;
  int n_mis = 0;

  fetch_queue #(.RESET_PC(32'h0), .DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .IFreq(IFreq), .IFaddr(IFaddr), .IFrdata(IFrdata),
    .IFredirect(IFredirect), .IFtarget(IFtarget),
    .IFvalid(IFvalid), .IFready(IFready),
    .IFinstr(IFinstr), .IFpc(IFpc), .IFcount(IFcount)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_mis++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: sample the request, then present its response after the edge.
  task automatic tick();
    logic        r;
    logic [31:0] a;
    r = IFreq;
    a = IFaddr;
    @(posedge clk);
    #1;
    IFrdata = r ? a + 32'h100 : 32'hDEAD_BEEF;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    IFredirect = 1'b0;
    @(posedge clk);
    #1;
    IFrdata = 32'hDEAD_BEEF;
    reset = 1'b0;
    #1;
  endtask

  initial begin
    // Reset state
    IFready = 1'b1;
    @(posedge clk);
    #1;
    check("rst_req",   {31'h0, IFreq},   32'h0);
    check("rst_valid", {31'h0, IFvalid}, 32'h0);
    check("rst_count", {29'h0, IFcount}, 32'h0);
    check("rst_instr", IFinstr, 32'h0);
    check("rst_pc",    IFpc,    32'h0);
    check("rst_addr",  IFaddr,  32'h0);

    // Streaming with IFready high
    reset = 1'b0;
    #1;
    for (int k = 0; k < 8; k++) begin
      check("s_addr", IFaddr, 32'(4 * k));
      check("s_req", {31'h0, IFreq}, 32'h1);
      check("s_valid", {31'h0, IFvalid}, (k >= LAT) ? 32'h1 : 32'h0);
      check("s_count", {29'h0, IFcount}, (!BYP && k >= 2) ? 32'h1 : 32'h0);
      if (k >= LAT) begin
        check("s_pc", IFpc, 32'(4 * (k - LAT)));
        check("s_instr", IFinstr, 32'h100 + 32'(4 * (k - LAT)));
      end
      tick();
    end

    // Backpressure: fill to DEPTH, hold head, then drain in order
    do_reset();
    IFready = 1'b0;
    #1;
    for (int k = 0; k < 10; k++) begin
      check("bp_req", {31'h0, IFreq}, (k < 4) ? 32'h1 : 32'h0);
      check("bp_count", {29'h0, IFcount}, (k < 2) ? 32'h0 : (k < 5) ? 32'(k - 1) : 32'h4);
      check("bp_valid", {31'h0, IFvalid}, (k >= LAT) ? 32'h1 : 32'h0);
      if (k >= LAT) check("bp_pc", IFpc, 32'h0);
      tick();
    end
    IFready = 1'b1;
    #1;
    for (int k = 0; k < 6; k++) begin
      check("dr_valid", {31'h0, IFvalid}, 32'h1);
      check("dr_pc", IFpc, 32'(4 * k));
      check("dr_instr", IFinstr, 32'h100 + 32'(4 * k));
      tick();
    end

    // Redirect with 3 queued entries and one request in flight
    do_reset();
    IFready = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) tick();
    check("rd_pre_count", {29'h0, IFcount}, 32'h3);
    IFready = 1'b1;
    IFredirect = 1'b1;
    IFtarget = 32'h40;
    #1;
    check("rd_req_blk", {31'h0, IFreq}, 32'h0);
    tick();
    IFredirect = 1'b0;
    #1;
    check("rd_count", {29'h0, IFcount}, 32'h0);
    check("rd_valid", {31'h0, IFvalid}, 32'h0);
    check("rd_addr", IFaddr, 32'h40);
    check("rd_req", {31'h0, IFreq}, 32'h1);
    for (int k = 0; k < LAT; k++) tick();
    check("rd_first_valid", {31'h0, IFvalid}, 32'h1);
    check("rd_first_pc", IFpc, 32'h40);
    check("rd_first_instr", IFinstr, 32'h140);

    // Back-to-back redirects, last (unaligned) target wins
    for (int k = 0; k < 3; k++) tick();
    IFredirect = 1'b1;
    IFtarget = 32'h80;
    #1;
    tick();
    IFtarget = 32'h43;
    #1;
    check("rr_req_blk", {31'h0, IFreq}, 32'h0);
    tick();
    IFredirect = 1'b0;
    #1;
    check("rr_addr", IFaddr, 32'h40);
    check("rr_count", {29'h0, IFcount}, 32'h0);
    for (int k = 0; k < LAT; k++) tick();
    check("rr_pc", IFpc, 32'h40);
    check("rr_instr", IFinstr, 32'h140);

    // Asynchronous reset pulse between clock edges
    for (int k = 0; k < 3; k++) tick();
    check("ar_pre_valid", {31'h0, IFvalid}, 32'h1);
    #2;
    reset = 1'b1;
    #1;
    check("ar_valid", {31'h0, IFvalid}, 32'h0);
    check("ar_req", {31'h0, IFreq}, 32'h0);
    check("ar_count", {29'h0, IFcount}, 32'h0);
    #1;
    reset = 1'b0;
    #1;
    check("ar_addr", IFaddr, 32'h0);
    check("ar_req_after", {31'h0, IFreq}, 32'h1);
    for (int k = 0; k < LAT; k++) tick();
    check("ar_pc", IFpc, 32'h0);
    check("ar_instr", IFinstr, 32'h100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction fetch stage sitting directly upstream of the single-cycle control/decode datapath.
- Generates word addresses to the instruction memory and captures the returned instruction words.
- Buffers the words, with their PCs, in a small FIFO and hands them to decode over a valid/ready handshake.
- Supports a redirect (taken branch/jump) that flushes all buffered and in-flight fetches.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address issued first after reset.
- DEPTH, 4, queue entries; power of two, >= 2.
- CW, $clog2(DEPTH)+1, width of occupancy count.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- IFreq  output  1  fetch request to instruction memory this cycle.
- IFaddr  output  32  fetch byte address, word aligned.
- IFrdata  input  32  instruction word; valid the cycle after the IFreq cycle (fixed 1-cycle latency).
- IFredirect  input  1  flush and restart fetch at IFtarget.
- IFtarget  input  32  redirect byte address.
- IFvalid  output  1  head entry available to decode.
- IFready  input  1  decode accepts head entry.
- IFinstr  output  32  head instruction word.
- IFpc  output  32  PC of head instruction.
- IFcount  output  CW  entries currently held.

Behaviour:
- Reset (async, while high):
  - fetch_pc=RESET_PC; queue empty; read/write pointers 0; pending flag 0.
  - IFreq=0, IFvalid=0, IFinstr=0, IFpc=0, IFcount=0.
- Request issue (combinational):
  - IFreq = !reset && !IFredirect && (count + pending) < DEPTH.
  - IFaddr = fetch_pc.
  - On issue: fetch_pc <= fetch_pc+4, wrapping mod 2^32; pending <= 1; pend_pc <= fetch_pc.
  - Otherwise pending <= 0.
- Response capture:
  - When pending=1 and no redirect, {pend_pc, IFrdata} is written at the write pointer at the end of that cycle.
  - Credit accounting guarantees no overflow.
- Output:
  - IFvalid = (count != 0).
  - IFinstr/IFpc = head entry when IFvalid=1, else 0.
  - Pop when IFvalid && IFready.
  - Outputs are stable while IFvalid && !IFready, except on redirect.
- Latency: request in cycle t -> data on IFrdata in t+1 -> IFvalid with that entry in t+2.
- Steady state with IFready held high: one instruction per cycle after a 2-cycle fill.
- Simultaneous push and pop: count unchanged; both pointers advance mod DEPTH.
- Full (count=DEPTH): IFreq=0.
- count=DEPTH-1 with pending=1: IFreq=0, so there is no overflow.
- Pop in the cycle a slot frees: the freed slot is usable for issue the next cycle (count registered).
- Redirect cycle:
  - Queue cleared (count=0, pointers 0); pending response discarded; any pop ignored; IFreq=0.
  - fetch_pc <= {IFtarget[31:2],2'b00}; IFtarget[1:0] is ignored.
  - First request to the target issues the next cycle.
  - Redirect on consecutive cycles: last target wins.
- Reset asserted mid-operation: everything cleared immediately; in-flight response ignored.

Optional Feature:
- Macro: FETCH_QUEUE_BYPASS_EN.
- Defined:
  - When count=0, pending=1 and no redirect, IFrdata/pend_pc drive IFinstr/IFpc combinationally with IFvalid=1.
  - If IFready=1 that cycle, the word is consumed and not written to the queue; otherwise it is enqueued.
  - Latency becomes request t -> IFvalid t+1.
- Undefined: no bypass; latency as above (t+2).

Test Plan:
- Reset release, RESET_PC=0, IFready=1, memory returns addr+32'h100:
  - IFaddr 0,4,8,... on consecutive cycles.
  - IFvalid first high 2 cycles after the first IFreq, with IFpc=0 and IFinstr=0x100, then 4/0x104 and so on, one per cycle.
- IFready=0 for 10 cycles:
  - IFreq drops after 4 issues; IFcount saturates at 4.
  - IFpc holds 0.
  - Raising IFready drains 0,4,8,12 with no loss or duplication.
- Redirect: IFredirect=1, IFtarget=0x40 while the queue holds 3 entries and one request is pending:
  - Next cycle IFcount=0, IFvalid=0, IFaddr=0x40.
  - The discarded response never appears; first IFpc output is 0x40.
- IFtarget=0x43 redirect -> IFaddr=0x40.
- Async reset pulse mid-stream (not clock aligned) -> IFvalid, IFreq and IFcount drop immediately; after release IFaddr=RESET_PC.
- With FETCH_QUEUE_BYPASS_EN, empty queue, IFready=1: IFvalid with IFpc=0 in the cycle after the first request; IFcount stays 0 throughout streaming.
